uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and successor to the single-format 8N1 transmitter. Adds the following to the serial engine:
- an input FIFO with valid/ready handshake
- a runtime baud divisor
- selectable parity (none/even/odd)
- 1 or 2 stop bits

It sits between the host-side byte stream and the tx pin. A matching receiver consumes the same configuration.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_cfg.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

    // Parity selection as presented on cfg_parity.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    // Serial engine states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Smallest usable clocks-per-bit; smaller divisors are clamped to this.
    localparam int MIN_DIV = 2;

    // True when the parity mode inserts a parity bit (reserved acts as none).
    function automatic logic parity_enabled(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with occupancy count. Read data is the head entry,
// available combinationally so a pop and the data capture share one edge.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [PTR_W:0]   CNT_ONE   = 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

    logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W:0]        count_reg;
    logic                  do_push;
    logic                  do_pop;

    // No push-through: a full FIFO refuses writes even when popping.
    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem_reg[rd_ptr_reg];
    assign level   = count_reg;

    // Store the incoming word at the write pointer (data path, no reset needed).
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: input FIFO, runtime baud divisor,
// none/even/odd parity and one or two stop bits. Configuration is captured
// at each frame start so changes mid-frame only affect the next frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DIV_WIDTH-1:0]         cfg_div,
    input  logic [1:0]                   cfg_parity,
    input  logic                         cfg_stop2,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0]     IDX_ONE  = 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = 1;
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(MIN_DIV);

    // FIFO interface
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_data;

    // Engine state
    tx_state_e             state_reg,       state_next;
    logic                  tx_reg,          tx_next;
    logic [DIV_WIDTH-1:0]  baud_reg,        baud_next;
    logic [IDX_W-1:0]      idx_reg,         idx_next;
    logic [DATA_WIDTH-1:0] shift_reg,       shift_next;
    logic [DIV_WIDTH-1:0]  div_reg,         div_next;
    logic                  par_en_reg,      par_en_next;
    logic                  par_bit_reg,     par_bit_next;
    logic                  stop2_reg,       stop2_next;
    logic                  stop_second_reg, stop_second_next;

    logic                  start_frame;
    logic [DIV_WIDTH-1:0]  div_eff;
    logic                  baud_done;

    assign s_ready   = !fifo_full;
    assign div_eff   = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
    assign baud_done = (baud_reg == '0);
    assign tx        = tx_reg;
    assign busy      = (state_reg != IDLE);

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_data (s_data),
        .wr_en   (s_valid && s_ready),
        .rd_en   (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Register the engine state; reset drops any partial frame and idles the line.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            tx_reg          <= 1'b1;
            baud_reg        <= '0;
            idx_reg         <= '0;
            shift_reg       <= '0;
            div_reg         <= DIV_MIN;
            par_en_reg      <= 1'b0;
            par_bit_reg     <= 1'b0;
            stop2_reg       <= 1'b0;
            stop_second_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tx_reg          <= tx_next;
            baud_reg        <= baud_next;
            idx_reg         <= idx_next;
            shift_reg       <= shift_next;
            div_reg         <= div_next;
            par_en_reg      <= par_en_next;
            par_bit_reg     <= par_bit_next;
            stop2_reg       <= stop2_next;
            stop_second_reg <= stop_second_next;
        end
    end

    // Next-state logic: each bit lasts div clocks, timed by a down-counter.
    always_comb begin
        state_next       = state_reg;
        tx_next          = tx_reg;
        baud_next        = baud_reg;
        idx_next         = idx_reg;
        shift_next       = shift_reg;
        div_next         = div_reg;
        par_en_next      = par_en_reg;
        par_bit_next     = par_bit_reg;
        stop2_next       = stop2_reg;
        stop_second_next = stop_second_reg;
        fifo_pop         = 1'b0;
        start_frame      = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    idx_next   = '0;
                    baud_next  = div_reg - DIV_ONE;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - DIV_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = div_reg - DIV_ONE;
                    if (idx_reg == IDX_LAST) begin
                        stop_second_next = 1'b0;
                        if (par_en_reg) begin
                            tx_next    = par_bit_reg;
                            state_next = PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        idx_next   = idx_reg + IDX_ONE;
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    baud_next = baud_reg - DIV_ONE;
                end
            end
            PARITY: begin
                if (baud_done) begin
                    tx_next          = 1'b1;
                    baud_next        = div_reg - DIV_ONE;
                    stop_second_next = 1'b0;
                    state_next       = STOP;
                end else begin
                    baud_next = baud_reg - DIV_ONE;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (stop2_reg && !stop_second_reg) begin
                        // Second stop bit: simply run the counter once more.
                        stop_second_next = 1'b1;
                        baud_next        = div_reg - DIV_ONE;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        start_frame = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg - DIV_ONE;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        // Frame launch shared by IDLE and back-to-back STOP: pop and latch config.
        if (start_frame) begin
            fifo_pop         = 1'b1;
            shift_next       = fifo_data;
            div_next         = div_eff;
            par_en_next      = parity_enabled(parity_e'(cfg_parity));
            par_bit_next     = (^fifo_data) ^ (cfg_parity == PAR_ODD);
            stop2_next       = cfg_stop2;
            stop_second_next = 1'b0;
            baud_next        = div_eff - DIV_ONE;
            tx_next          = 1'b0;
            state_next       = START;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg: captures the tx waveform clock by clock
// and compares it with a waveform built from the frame format.
module tb_uart_tx_cfg;

    localparam int DW   = 8;
    localparam int FD   = 4;
    localparam int DIVW = 16;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [DW-1:0]         s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DIVW-1:0]       cfg_div;
    logic [1:0]            cfg_parity;
    logic                  cfg_stop2;
    logic                  tx;
    logic                  busy;
    logic [$clog2(FD):0]   fifo_level;

    int n_checks = 0;
    int n_fails  = 0;

    logic [127:0] exp_wave;
    int           exp_len;
    logic [127:0] cap_wave;
    int           cap_wait;
    int           stall5;

    uart_tx_cfg #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic exp_clear();
        exp_wave = '0;
        exp_len  = 0;
    endtask

    task automatic exp_bit(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_wave[exp_len] = b;
            exp_len++;
        end
    endtask

    // par: 0 none, 1 even, 2 odd
    task automatic exp_frame(input logic [7:0] d, input int div, input int par, input bit stop2);
        int eff;
        eff = (div < 2) ? 2 : div;
        exp_bit(1'b0, eff);
        for (int b = 0; b < 8; b++) exp_bit(d[b], eff);
        if (par == 1) exp_bit(^d, eff);
        else if (par == 2) exp_bit(~^d, eff);
        exp_bit(1'b1, stop2 ? 2 * eff : eff);
    endtask

    task automatic push(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Wait (bounded) for the start bit, then record n samples of tx,
    // optionally changing cfg_div before sample chg_at.
    task automatic capture(input int n, input int chg_at, input logic [DIVW-1:0] chg_div);
        cap_wave = '0;
        cap_wait = 0;
        do begin
            @(posedge clk); #1;
            cap_wait++;
        end while (tx !== 1'b0 && cap_wait < 200);
        check("start_seen", (cap_wait < 200), 1'b1);
        cap_wave[0] = tx;
        for (int i = 1; i < n; i++) begin
            if (i == chg_at) cfg_div = chg_div;
            @(posedge clk); #1;
            cap_wave[i] = tx;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [6];
        int         n_act;

        rstn       = 1'b0;
        s_data     = '0;
        s_valid    = 1'b0;
        cfg_div    = 16'd4;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", s_ready, 1'b1);
        check("rst_level", fifo_level, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 8N1, div 4, 0xA5: 40-clock frame, tx falls one edge after the push
        push(8'hA5);
        check("8n1_level_after_push", fifo_level, 1);
        check("8n1_tx_before_start", tx, 1'b1);
        capture(41, -1, '0);
        check("8n1_latency", cap_wait, 1);
        exp_clear(); exp_frame(8'hA5, 4, 0, 1'b0); exp_bit(1'b1, 1);
        check("8n1_wave", cap_wave, exp_wave);
        check("8n1_busy_end", busy, 1'b0);
        check("8n1_level_end", fifo_level, 0);

        // Even parity, two stop bits: parity 0, 48-clock frame
        cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        push(8'hA5);
        capture(49, -1, '0);
        exp_clear(); exp_frame(8'hA5, 4, 1, 1'b1); exp_bit(1'b1, 1);
        check("8e2_wave", cap_wave, exp_wave);
        check("8e2_busy_end", busy, 1'b0);

        // Odd parity, two stop bits: parity 1
        cfg_parity = 2'b10;
        push(8'hA5);
        capture(49, -1, '0);
        exp_clear(); exp_frame(8'hA5, 4, 2, 1'b1); exp_bit(1'b1, 1);
        check("8o2_wave", cap_wave, exp_wave);

        // Reserved parity behaves as none
        cfg_parity = 2'b11; cfg_stop2 = 1'b0;
        push(8'h81);
        capture(41, -1, '0);
        exp_clear(); exp_frame(8'h81, 4, 0, 1'b0); exp_bit(1'b1, 1);
        check("rsvd_par_wave", cap_wave, exp_wave);

        // Divisor clamp: 0 and 1 both give 2 clocks per bit
        cfg_parity = 2'b00; cfg_div = 16'd0;
        push(8'h3C);
        capture(21, -1, '0);
        exp_clear(); exp_frame(8'h3C, 0, 0, 1'b0); exp_bit(1'b1, 1);
        check("div0_wave", cap_wave, exp_wave);
        cfg_div = 16'd1;
        push(8'hC3);
        capture(21, -1, '0);
        exp_clear(); exp_frame(8'hC3, 1, 0, 1'b0); exp_bit(1'b1, 1);
        check("div1_wave", cap_wave, exp_wave);

        // Config change mid-frame: frame 1 keeps div 4, frame 2 uses div 8
        cfg_div = 16'd4;
        push(8'h5A);
        fork
            capture(121, 10, 16'd8);
            push(8'h96);
        join
        exp_clear(); exp_frame(8'h5A, 4, 0, 1'b0); exp_frame(8'h96, 8, 0, 1'b0); exp_bit(1'b1, 1);
        check("cfgchg_wave", cap_wave, exp_wave);
        check("cfgchg_busy_end", busy, 1'b0);

        // Back-to-back at div 2: one frame in flight + 4 queued fill the FIFO,
        // the next push stalls until the first frame's stop bit completes.
        cfg_div = 16'd2;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
        stall5 = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    int stall;
                    stall   = 0;
                    s_data  = words[k];
                    s_valid = 1'b1;
                    while (!s_ready && stall < 100) begin
                        @(posedge clk); #1;
                        stall++;
                    end
                    @(posedge clk); #1;
                    if (k == 4) begin
                        check("full_ready_low", s_ready, 1'b0);
                        check("full_level", fifo_level, 4);
                    end
                    if (k == 5) stall5 = stall;
                end
                s_valid = 1'b0;
            end
            capture(121, -1, '0);
        join
        check("full_stall_cycles", stall5, 17);
        exp_clear();
        for (int k = 0; k < 6; k++) exp_frame(words[k], 2, 0, 1'b0);
        exp_bit(1'b1, 1);
        check("b2b_wave", cap_wave, exp_wave);
        check("b2b_busy_end", busy, 1'b0);
        check("b2b_level_end", fifo_level, 0);

        // Reset mid-frame with two words queued
        cfg_div = 16'd4;
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("midrst_busy_before", busy, 1'b1);
        check("midrst_level_before", fifo_level, 2);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_level", fifo_level, 0);
        check("midrst_ready", s_ready, 1'b1);
        rstn = 1'b1;
        n_act = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) n_act++;
        end
        check("midrst_quiet", n_act, 0);

        // Engine still works after the reset
        push(8'h0F);
        capture(41, -1, '0);
        exp_clear(); exp_frame(8'h0F, 4, 0, 1'b0); exp_bit(1'b1, 1);
        check("postrst_wave", cap_wave, exp_wave);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
